uart_tx_arbiter: RTL

Round-robin arbiter and frame sequencer that shares one UART serial transmit line among four byte requesters. It grants one requester at a time, latches that requester's byte and serialises it as an 8N1 frame: start bit, 8 data bits LSB first, one stop bit. Bit timing is counted in clock cycles. It is the transmit-side counterpart of the `uart` receiver: at default parameters its `serial_out` drives a receiver `input_stream` directly at 25 MHz / 9600 baud.

---
 rtl/uart_tx_arbiter_if.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of the four-way UART transmit arbiter: byte requests
// in, grant/status and the serial line out, plus the sequencer state for observation.
interface uart_tx_arbiter_if;
  // Handshake: requester k raises req[k] with a stable byte on data_in[8k+:8]
  // and holds both until it sees the one-cycle grant[k] pulse; the byte is
  // captured on that same edge, so the requester may drop or reload afterwards.
  // Any req[k] still high after its grant counts as a fresh byte.
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  grant;
  logic [1:0]  active_id;
  logic        busy;
  logic        serial_out;
  logic [1:0]  state;

  modport master (
    output req,
    output data_in,
    input  grant,
    input  active_id,
    input  busy,
    input  serial_out,
    input  state
  );

  modport slave (
    input  req,
    input  data_in,
    output grant,
    output active_id,
    output busy,
    output serial_out,
    output state
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter for four byte requesters feeding one 8N1 UART transmit
// line; the granted byte is latched and shifted out LSB first.
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 2604
) (
  input  logic              clock,
  input  logic              reset_n,
  uart_tx_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [1:0]  last_grant_q;
  logic [1:0]  active_id_q;
  logic [3:0]  grant_q;
  logic        busy_q;
  logic        serial_q;

  logic [1:0]  winner_d;
  logic [7:0]  byte_d;
  logic        bit_done;

  // Walk from the lowest-priority slot (last_grant itself) to the highest
  // (last_grant+1) so the final matching assignment is the round-robin winner.
  always_comb begin
    winner_d = last_grant_q;
    for (int i = 4; i >= 1; i--) begin
      if (bus.req[last_grant_q + 2'(i)]) begin
        winner_d = last_grant_q + 2'(i);
      end
    end
  end

  assign byte_d   = bus.data_in[{winner_d, 3'b000} +: 8];
  assign bit_done = (cnt_q == BIT_LAST);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      last_grant_q <= 2'd3;
      active_id_q  <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      serial_q     <= 1'b1;
    end else begin
      grant_q <= '0;
      unique case (state_q)
        IDLE: begin
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
          // The grant edge is also the first cycle of the start bit.
          if (|bus.req) begin
            shift_q      <= byte_d;
            grant_q      <= 4'(1) << winner_d;
            active_id_q  <= winner_d;
            last_grant_q <= winner_d;
            cnt_q        <= '0;
            serial_q     <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= START;
          end
        end
        START: begin
          if (bit_done) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            serial_q  <= shift_q[0];
            state_q   <= DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              serial_q <= 1'b1;
              state_q  <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              serial_q  <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.active_id  = active_id_q;
  assign bus.busy       = busy_q;
  assign bus.serial_out = serial_q;
  assign bus.state      = state_q;

endmodule
